instruction_fetch_queue: RTL
============================

// Module: instruction_fetch_queue
// PURPOSE
// - Parametrised fetch front end for the multi-instruction RV32I core; replaces the direct pc->program_memory read.
// - Owns fetch PC and word-addressed program_memory array (bench-loadable hierarchically: mut.fetch.program_memory[i]).
// - Prefetches into a DEPTH-entry FIFO of {pc, instr}; core consumes via valid/ready; branch/jump redirect flushes.
// PARAMETERS
// - XLEN        32   width of pc and instruction words
// - DEPTH       4    queue entries; power of two, >=2
// - PMEM_WORDS  64   program_memory words; power of two
// - RESET_PC    0    fetch_pc value after reset; low two bits must be 0
// PORTS
// - clk             in   1                  clock, rising edge
// - reset           in   1                  asynchronous, active-low; asserted when 0
// - fetch_en        in   1                  1 = fetch allowed this cycle
// - redirect_valid  in   1                  1 = flush queue, restart fetch at redirect_pc
// - redirect_pc     in   XLEN               new fetch address; bits [1:0] ignored
// - out_ready       in   1                  consumer accepts head entry
// - out_valid       out  1                  head entry valid (count != 0)
// - out_pc          out  XLEN               pc of head entry
// - out_instr       out  XLEN               instruction of head entry
// - count           out  $clog2(DEPTH+1)    current occupancy, 0..DEPTH
// BEHAVIOUR
// - Reset (reset==0, async): fetch_pc=RESET_PC, rd/wr ptr=0, count=0, out_valid=0; out_pc/out_instr don't-care while out_valid=0. program_memory not cleared.
// - pop  = out_valid & out_ready.
// - push = fetch_en & ~redirect_valid & (count<DEPTH | pop).
// - Push: entry {fetch_pc, program_memory[fetch_pc[2+:$clog2(PMEM_WORDS)]]} written at wr ptr; fetch_pc += 4.
// - Memory index uses address bits only: fetch_pc beyond PMEM_WORDS*4 wraps onto the array; out_pc keeps the full pc.
// - fetch_pc wraps modulo 2^XLEN; ptrs wrap modulo DEPTH.
// - Latency: entry pushed at edge N is visible on out_* after edge N (combinational read of head); reset released -> first out_valid after first posedge with fetch_en=1.
// - Full (count==DEPTH) & ~pop: no push, fetch_pc holds. Full & pop: push and pop, count stays DEPTH.
// - Empty: out_valid=0, out_ready ignored; push alone -> count=1 next cycle.
// - Simultaneous push+pop: count unchanged, both ptrs advance.
// - redirect_valid=1: highest priority; next edge count=0, ptrs=0, fetch_pc=redirect_pc & ~3, no push.
//   A pop in the redirect cycle still counts as accepted by the consumer; all other entries discarded.
// - redirect with fetch_en=0: flush still happens; fetch resumes when fetch_en returns.
// - fetch_en=0: no push; pops continue; fetch_pc holds.
// - count is registered; out_valid = (count!=0), no combinational path from inputs to out_valid.
// CONFIGURATION
// - `define FETCH_PERF_EN: adds outputs fetched_count (32, +1 per push) and flush_count (32, +1 per redirect cycle);
//   both reset to 0 async, wrap at 2^32, not cleared by redirect.
// - Without FETCH_PERF_EN: ports and counters absent; core behaviour identical.
// TESTING
// - Fill: mem[0]=32'h07800293 (addi x5,x0,120), mem[1..4] loaded, fetch_en=1, out_ready=0 -> after 4 posedges count=4, out_pc=0, out_instr=32'h07800293; more clocks keep count=4.
// - Stream: out_ready=1 continuously -> one pop per cycle from 2nd cycle, out_pc 0,4,8,12,16 consecutive, no gaps, count=1 steady.
// - Full+pop: count=4, single out_ready pulse -> count stays 4, head out_pc advances 0->4, tail gains pc 16.
// - Redirect: queue full, redirect_valid=1, redirect_pc=32'h13 -> next cycle count=0, out_valid=0; following cycle out_valid=1, out_pc=32'h10, out_instr=mem[4].
// - Reset mid-run: count=3, drive reset=0 between edges -> out_valid=0 and count=0 immediately (no edge); after release out_pc=RESET_PC.
// - Wrap: PMEM_WORDS=8, fetch reaches pc 32'h20 -> out_pc=32'h20, out_instr=mem[0]; with FETCH_PERF_EN fetched_count=9 at that entry's push.

Source files
------------

// File: rtl/instruction_fetch_queue.sv
// Fetch front end: owns the fetch PC and program memory, and prefetches {pc, instr} pairs into a DEPTH-entry FIFO.
// Optional performance counters (fetched_count, flush_count) are enabled by defining FETCH_PERF_EN.
module instruction_fetch_queue #(
  parameter int              XLEN       = 32,
  parameter int              DEPTH      = 4,
  parameter int              PMEM_WORDS = 64,
  parameter logic [XLEN-1:0] RESET_PC   = '0
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         fetch_en,
  input  logic                         redirect_valid,
  input  logic [XLEN-1:0]              redirect_pc,
  input  logic                         out_ready,
  output logic                         out_valid,
  output logic [XLEN-1:0]              out_pc,
  output logic [XLEN-1:0]              out_instr,
  output logic [$clog2(DEPTH+1)-1:0]   count
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]                  fetched_count,
  output logic [31:0]                  flush_count
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);
  localparam int IDX_W = $clog2(PMEM_WORDS);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  // Loaded hierarchically by the surrounding core/bench; no write port.
  logic [XLEN-1:0] program_memory [PMEM_WORDS];

  logic [XLEN-1:0] pc_store    [DEPTH];
  logic [XLEN-1:0] instr_store [DEPTH];

  logic [XLEN-1:0]  fetch_pc_reg, fetch_pc_next;
  logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next;
  logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
  logic [CNT_W-1:0] count_reg, count_next;
  logic [XLEN-1:0]  fetch_word;
  logic             pop;
  logic             push;

  assign fetch_word = program_memory[fetch_pc_reg[2 +: IDX_W]];
  assign pop        = (count_reg != '0) & out_ready;
  // A full queue can still accept a push when the head leaves in the same cycle.
  assign push       = fetch_en & ~redirect_valid & ((count_reg < FULL) | pop);

  always_comb begin
    fetch_pc_next = fetch_pc_reg;
    rd_ptr_next   = rd_ptr_reg;
    wr_ptr_next   = wr_ptr_reg;
    count_next    = count_reg;
    if (redirect_valid) begin
      fetch_pc_next = redirect_pc & ~XLEN'(3);
      rd_ptr_next   = '0;
      wr_ptr_next   = '0;
      count_next    = '0;
    end else begin
      if (push) begin
        fetch_pc_next = fetch_pc_reg + XLEN'(4);
        wr_ptr_next   = wr_ptr_reg + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_next = rd_ptr_reg + PTR_W'(1);
      end
      if (push && !pop) begin
        count_next = count_reg + CNT_W'(1);
      end else if (pop && !push) begin
        count_next = count_reg - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_pc_reg <= RESET_PC;
      rd_ptr_reg   <= '0;
      wr_ptr_reg   <= '0;
      count_reg    <= '0;
    end else begin
      fetch_pc_reg <= fetch_pc_next;
      rd_ptr_reg   <= rd_ptr_next;
      wr_ptr_reg   <= wr_ptr_next;
      count_reg    <= count_next;
    end
  end

  // Entry storage carries no reset: contents are only observed while counted valid.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_store[wr_ptr_reg]    <= fetch_pc_reg;
      instr_store[wr_ptr_reg] <= fetch_word;
    end
  end

  assign out_valid = (count_reg != '0);
  assign out_pc    = pc_store[rd_ptr_reg];
  assign out_instr = instr_store[rd_ptr_reg];
  assign count     = count_reg;

`ifdef FETCH_PERF_EN
  logic [31:0] fetched_count_reg;
  logic [31:0] flush_count_reg;

  // Counters survive redirects; only reset clears them.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetched_count_reg <= '0;
      flush_count_reg   <= '0;
    end else begin
      if (push) fetched_count_reg <= fetched_count_reg + 32'd1;
      if (redirect_valid) flush_count_reg <= flush_count_reg + 32'd1;
    end
  end

  assign fetched_count = fetched_count_reg;
  assign flush_count   = flush_count_reg;
`endif

endmodule
